aes_encrypt_iter: RTL and testbench

Iterative AES-128 encryption core: the forward-direction counterpart to the team's decryption datapath. Performs one cipher round per clock, using SubBytes, ShiftRows (rows rotated left by 0/1/2/3 bytes), MixColumns and an on-the-fly key-schedule step. It takes a 128-bit plaintext and key on a start pulse and returns the ciphertext with a one-cycle valid strobe. It sits alongside the decryption core so the two can be paired for round-trip checking.

---
 rtl/aes_encrypt_iter.sv | 142 ++++++++++++++
 tb/tb_aes_encrypt_iter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryption core: one cipher round per clock, with the key schedule
// computed on the fly and a one-cycle valid strobe on completion.
module aes_encrypt_iter (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [127:0] i_plaintext,
  input  logic [127:0] i_key,
  output logic [127:0] o_ciphertext,
  output logic         o_valid,
  output logic         o_busy
);

  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t         fsm_reg;
  logic [127:0] state_reg;
  logic [127:0] rk_reg;
  logic [3:0]   round_reg;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, which also maps 0 to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [7:0]   sb [16];
  logic [7:0]   sr [16];
  logic [7:0]   mc [16];
  logic [127:0] sr_flat;
  logic [127:0] mc_flat;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  w0_next, w1_next, w2_next, w3_next;
  logic [127:0] rk_next;
  logic [127:0] round_out;

  assign rot_word = {rk_reg[23:0], rk_reg[31:24]};

  // Byte gi sits at row gi%4, column gi/4; ShiftRows pulls row r from column (c+r)%4.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_bytes
      assign sb[gi] = sbox(state_reg[127-8*gi -: 8]);
      assign sr[gi] = sb[4*(((gi/4) + (gi%4)) % 4) + (gi%4)];
      assign sr_flat[127-8*gi -: 8] = sr[gi];
      assign mc_flat[127-8*gi -: 8] = mc[gi];
    end
    for (gi = 0; gi < 4; gi++) begin : g_cols
      assign mc[4*gi]   = xtime(sr[4*gi]) ^ xtime(sr[4*gi+1]) ^ sr[4*gi+1] ^ sr[4*gi+2] ^ sr[4*gi+3];
      assign mc[4*gi+1] = sr[4*gi] ^ xtime(sr[4*gi+1]) ^ xtime(sr[4*gi+2]) ^ sr[4*gi+2] ^ sr[4*gi+3];
      assign mc[4*gi+2] = sr[4*gi] ^ sr[4*gi+1] ^ xtime(sr[4*gi+2]) ^ xtime(sr[4*gi+3]) ^ sr[4*gi+3];
      assign mc[4*gi+3] = xtime(sr[4*gi]) ^ sr[4*gi] ^ sr[4*gi+1] ^ sr[4*gi+2] ^ xtime(sr[4*gi+3]);
      assign sub_word[31-8*gi -: 8] = sbox(rot_word[31-8*gi -: 8]);
    end
  endgenerate

  assign w0_next   = rk_reg[127:96] ^ sub_word ^ {rcon(round_reg), 24'h000000};
  assign w1_next   = rk_reg[95:64] ^ w0_next;
  assign w2_next   = rk_reg[63:32] ^ w1_next;
  assign w3_next   = rk_reg[31:0]  ^ w2_next;
  assign rk_next   = {w0_next, w1_next, w2_next, w3_next};
  assign round_out = ((round_reg == 4'd10) ? sr_flat : mc_flat) ^ rk_next;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fsm_reg      <= IDLE;
      round_reg    <= 4'd0;
      state_reg    <= 128'd0;
      rk_reg       <= 128'd0;
      o_ciphertext <= 128'd0;
      o_valid      <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (fsm_reg)
        IDLE: begin
          if (i_start) begin
            state_reg <= i_plaintext ^ i_key;
            rk_reg    <= i_key;
            round_reg <= 4'd1;
            o_busy    <= 1'b1;
            fsm_reg   <= RUN;
          end
        end
        RUN: begin
          state_reg <= round_out;
          if (round_reg == 4'd10) begin
            o_ciphertext <= round_out;
            o_valid      <= 1'b1;
            o_busy       <= 1'b0;
            fsm_reg      <= IDLE;
          end else begin
            rk_reg    <= rk_next;
            round_reg <= round_reg + 4'd1;
          end
        end
        default: fsm_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Self-checking bench for aes_encrypt_iter: known-answer table, multi-cycle corner
// sequences, and random blocks checked against a byte-array AES model plus its inverse.
module tb_aes_encrypt_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic [127:0] ciphertext;
  logic         valid;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] sbox_t [256];
  logic [7:0] inv_t  [256];

  always #5 clk = ~clk;

  aes_encrypt_iter dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_plaintext (plaintext),
    .i_key       (key),
    .o_ciphertext(ciphertext),
    .o_valid     (valid),
    .o_busy      (busy)
  );

  typedef struct {
    logic [127:0] k;
    logic [127:0] p;
    logic [127:0] c;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Carry-less product followed by polynomial reduction modulo 0x11b.
  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    int acc;
    acc = 0;
    for (int i = 0; i < 8; i++)
      if (b[i]) acc = acc ^ (int'(a) << i);
    for (int k = 14; k >= 8; k--)
      if (acc[k]) acc = acc ^ (32'h11b << (k - 8));
    return acc[7:0];
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] k, input int rnd);
    logic [31:0] w [4];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int r = 0; r < rnd; r++) begin
      t = {sbox_t[w[3][23:16]], sbox_t[w[3][15:8]], sbox_t[w[3][7:0]], sbox_t[w[3][31:24]]};
      w[0] = w[0] ^ t ^ {rc, 24'h0};
      w[1] = w[1] ^ w[0];
      w[2] = w[2] ^ w[1];
      w[3] = w[3] ^ w[2];
      rc = mul(rc, 8'h02);
    end
    return {w[0], w[1], w[2], w[3]};
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] k, input logic [127:0] p);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] rk;
    logic [127:0] res;
    rk = round_key(k, 0);
    for (int n = 0; n < 16; n++) s[n] = p[127-8*n -: 8] ^ rk[127-8*n -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int n = 0; n < 16; n++) s[n] = sbox_t[s[n]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++) begin
        if (rnd < 10) begin
          s[4*c]   = mul(t[4*c],8'h02) ^ mul(t[4*c+1],8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ mul(t[4*c+1],8'h02) ^ mul(t[4*c+2],8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ mul(t[4*c+2],8'h02) ^ mul(t[4*c+3],8'h03);
          s[4*c+3] = mul(t[4*c],8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ mul(t[4*c+3],8'h02);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
        end
      end
      rk = round_key(k, rnd);
      for (int n = 0; n < 16; n++) s[n] = s[n] ^ rk[127-8*n -: 8];
    end
    for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
    return res;
  endfunction

  // Straight inverse cipher, standing in for the companion decryption core.
  function automatic logic [127:0] model_dec(input logic [127:0] k, input logic [127:0] c_in);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] rk;
    logic [127:0] res;
    rk = round_key(k, 10);
    for (int n = 0; n < 16; n++) s[n] = c_in[127-8*n -: 8] ^ rk[127-8*n -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*((c+r)%4)+r] = s[4*c+r];
      rk = round_key(k, rnd);
      for (int n = 0; n < 16; n++) s[n] = inv_t[t[n]] ^ rk[127-8*n -: 8];
      if (rnd > 0) begin
        for (int n = 0; n < 16; n++) t[n] = s[n];
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = mul(t[4*c],8'h0e) ^ mul(t[4*c+1],8'h0b) ^ mul(t[4*c+2],8'h0d) ^ mul(t[4*c+3],8'h09);
          s[4*c+1] = mul(t[4*c],8'h09) ^ mul(t[4*c+1],8'h0e) ^ mul(t[4*c+2],8'h0b) ^ mul(t[4*c+3],8'h0d);
          s[4*c+2] = mul(t[4*c],8'h0d) ^ mul(t[4*c+1],8'h09) ^ mul(t[4*c+2],8'h0e) ^ mul(t[4*c+3],8'h0b);
          s[4*c+3] = mul(t[4*c],8'h0b) ^ mul(t[4*c+1],8'h0d) ^ mul(t[4*c+2],8'h09) ^ mul(t[4*c+3],8'h0e);
        end
      end
    end
    for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
    return res;
  endfunction

  task automatic build_sbox;
    logic [7:0] p;
    logic [7:0] q;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      sbox_t[p] = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
    for (int i = 0; i < 256; i++) inv_t[sbox_t[i]] = 8'(i);
  endtask

  // Issues one block from idle and waits (bounded) for its completion strobe.
  task automatic run_block(input logic [127:0] k, input logic [127:0] p, input string name,
                           output logic [127:0] got);
    int lat;
    key = k;
    plaintext = p;
    start = 1'b1;
    tick;
    start = 1'b0;
    check({name, "_busy"}, 128'(busy), 128'd1);
    lat = 0;
    while (!valid && lat < 30) begin
      tick;
      lat++;
    end
    check({name, "_latency"}, 128'(lat), 128'd10);
    check({name, "_busy_done"}, 128'(busy), 128'd0);
    got = ciphertext;
    tick;
    check({name, "_valid_drop"}, 128'(valid), 128'd0);
  endtask

  localparam logic [127:0] C1_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_P  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_C  = 128'h3925841d02dc09fbdc118597196a0b32;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs [4];
    logic [127:0] got;
    logic [127:0] rk_in, pt_in;
    int           lat, cnt;

    vecs[0] = '{C1_K, C1_P, C1_C};
    vecs[1] = '{B_K, B_P, B_C};
    vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    vecs[3] = '{128'h0, 128'h80000000000000000000000000000000,
                128'h3ad78e726c1ec02b7ebfe92b23d9ec34};

    build_sbox();
    rst = 1'b1;
    start = 1'b0;
    plaintext = '0;
    key = '0;
    tick;
    tick;
    check("reset_ciphertext", ciphertext, 128'd0);
    check("reset_valid", 128'(valid), 128'd0);
    check("reset_busy", 128'(busy), 128'd0);

    // Start asserted together with reset must not launch a block.
    key = C1_K;
    plaintext = C1_P;
    start = 1'b1;
    tick;
    check("start_under_reset_busy", 128'(busy), 128'd0);
    start = 1'b0;
    rst = 1'b0;
    tick;
    check("start_under_reset_idle", 128'(busy), 128'd0);

    for (int i = 0; i < 4; i++) begin
      check($sformatf("kat%0d_model", i), model_enc(vecs[i].k, vecs[i].p), vecs[i].c);
      run_block(vecs[i].k, vecs[i].p, $sformatf("kat%0d", i), got);
      check($sformatf("kat%0d_ct", i), got, vecs[i].c);
    end

    // App. B round-1 intermediate state.
    key = B_K;
    plaintext = B_P;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    check("appb_round1_state", dut.state_reg, 128'ha49c7ff2689f352b6b5bea43026a5049);
    lat = 1;
    while (!valid && lat < 30) begin
      tick;
      lat++;
    end
    check("appb_trace_ct", ciphertext, B_C);
    tick;

    // Restart and new inputs at E3 are ignored; then back-to-back App. B from the valid cycle.
    key = C1_K;
    plaintext = C1_P;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    key = B_K;
    plaintext = B_P;
    start = 1'b1;
    tick;
    start = 1'b0;
    lat = 3;
    while (!valid && lat < 30) begin
      tick;
      lat++;
    end
    check("midrun_latency", 128'(lat), 128'd10);
    check("midrun_ct", ciphertext, C1_C);
    start = 1'b1;
    tick;
    start = 1'b0;
    check("b2b_valid_drop", 128'(valid), 128'd0);
    check("b2b_busy", 128'(busy), 128'd1);
    lat = 1;
    while (!valid && lat < 30) begin
      tick;
      lat++;
    end
    check("b2b_spacing", 128'(lat), 128'd11);
    check("b2b_ct", ciphertext, B_C);
    tick;

    // Reset sampled at E5 discards the block.
    key = C1_K;
    plaintext = C1_P;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("midreset_busy", 128'(busy), 128'd0);
    check("midreset_valid", 128'(valid), 128'd0);
    check("midreset_ct", ciphertext, 128'd0);
    cnt = 0;
    repeat (15) begin
      tick;
      if (valid || busy) cnt++;
    end
    check("midreset_no_valid", 128'(cnt), 128'd0);
    run_block(C1_K, C1_P, "after_reset", got);
    check("after_reset_ct", got, C1_C);

    // Random blocks against the model, then back through the inverse cipher.
    for (int i = 0; i < 1000; i++) begin
      rk_in = {$urandom, $urandom, $urandom, $urandom};
      pt_in = {$urandom, $urandom, $urandom, $urandom};
      run_block(rk_in, pt_in, $sformatf("rnd%0d", i), got);
      check($sformatf("rnd%0d_ct", i), got, model_enc(rk_in, pt_in));
      check($sformatf("rnd%0d_roundtrip", i), model_dec(rk_in, got), pt_in);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
